// File: rtl/prog_clk_div_if.sv
// Configuration write bus for prog_clk_div: strobe, channel select and new half-period.
interface prog_clk_div_if #(
    parameter int CNT_W = 26
);
    logic             cfg_we;
    logic [3:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_half;

    modport master (output cfg_we, cfg_ch, cfg_half);
    modport slave  (input  cfg_we, cfg_ch, cfg_half);
endinterface

// File: rtl/prog_clk_div.sv
// Multi-channel runtime-programmable divider: 50% duty outputs, rising-edge ticks,
// shadowed half-periods that take effect only at half-period boundaries.
module prog_clk_div #(
    parameter int                      NUM_CH   = 4,
    parameter int                      CNT_W    = 26,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = {26'd25, 26'd25000, 26'd250000, 26'd25000000}
) (
    input  logic                clk_50mhz,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   en,
    input  logic                resync,
    prog_clk_div_if.slave       cfg,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   pend
);
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] act_q, act_d;
    logic [NUM_CH-1:0][CNT_W-1:0] shd_q, shd_d;
    logic [NUM_CH-1:0]            clk_q, clk_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            pend_q, pend_d;

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        clk_d  = clk_q;
        tick_d = '0;
        pend_d = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (resync) begin
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
                act_d[i]  = shd_q[i];
                pend_d[i] = 1'b0;
            end else if (en[i]) begin
                if (act_q[i] == '0) begin
                    // Illegal zero half-period parks the channel low until a legal shadow arrives
                    cnt_d[i] = '0;
                    clk_d[i] = 1'b0;
                    act_d[i] = shd_q[i];
                end else if (cnt_q[i] == act_q[i] - CNT_W'(1)) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = ~clk_q[i];
                    act_d[i]  = shd_q[i];
                    pend_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // A write in the same cycle as a boundary or resync lands after the shadow was consumed
            if (cfg.cfg_we && cfg.cfg_ch == 4'(i)) begin
                shd_d[i]  = cfg.cfg_half;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            cnt_q  <= '0;
            act_q  <= DEF_HALF;
            shd_q  <= DEF_HALF;
            clk_q  <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pend    = pend_q;
endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div with short default half-periods (ch0=3, ch1=6, ch2=4, ch3=25).
module tb_prog_clk_div;
    logic       clk_50mhz = 1'b0;
    logic       rst       = 1'b1;
    logic [3:0] en        = 4'hF;
    logic       resync    = 1'b0;
    logic [3:0] clk_out, tick, pend;
    int         n_chk = 0;
    int         n_err = 0;
    int         e     = 0;
    int         tcnt [4];
    int         bad;

    prog_clk_div_if #(.CNT_W(26)) cfg ();

    prog_clk_div #(
        .NUM_CH  (4),
        .CNT_W   (26),
        .DEF_HALF({26'd25, 26'd4, 26'd6, 26'd3})
    ) dut (
        .clk_50mhz(clk_50mhz),
        .rst      (rst),
        .en       (en),
        .resync   (resync),
        .cfg      (cfg.slave),
        .clk_out  (clk_out),
        .tick     (tick),
        .pend     (pend)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_50mhz);
        #1;
        e++;
    endtask

    task automatic run_to(input int t);
        while (e < t) cyc();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        e   = 0;
    endtask

    task automatic wr(input logic [3:0] ch, input logic [25:0] h);
        cfg.cfg_we   = 1'b1;
        cfg.cfg_ch   = ch;
        cfg.cfg_half = h;
    endtask

    initial begin
        cfg.cfg_we   = 1'b0;
        cfg.cfg_ch   = 4'd0;
        cfg.cfg_half = 26'd0;

        // Reset state and free-running periods
        cyc();
        reset_dut();
        chk("rst_clk", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_pend", 32'(pend), 0);
        for (int c = 0; c < 4; c++) tcnt[c] = 0;
        for (int k = 1; k <= 75; k++) begin
            cyc();
            for (int c = 0; c < 4; c++) tcnt[c] += int'(tick[c]);
            if (k == 24) chk("t1_e24_clk3", 32'(clk_out[3]), 0);
            if (k == 25) begin
                chk("t1_e25_clk3", 32'(clk_out[3]), 1);
                chk("t1_e25_tick3", 32'(tick[3]), 1);
            end
            if (k == 26) chk("t1_e26_tick3", 32'(tick[3]), 0);
            if (k == 49) chk("t1_e49_clk3", 32'(clk_out[3]), 1);
            if (k == 50) chk("t1_e50_clk3", 32'(clk_out[3]), 0);
            if (k == 75) chk("t1_e75_tick3", 32'(tick[3]), 1);
        end
        chk("t1_ticks0", 32'(tcnt[0]), 13);
        chk("t1_ticks1", 32'(tcnt[1]), 6);
        chk("t1_ticks2", 32'(tcnt[2]), 9);
        chk("t1_ticks3", 32'(tcnt[3]), 2);

        // Reprogram ch3 to 10 mid high phase
        reset_dut();
        run_to(29);
        wr(4'd3, 26'd10);
        run_to(30);
        cfg.cfg_we = 1'b0;
        chk("t2_e30_pend3", 32'(pend[3]), 1);
        chk("t2_e30_clk3", 32'(clk_out[3]), 1);
        run_to(49);
        chk("t2_e49_pend3", 32'(pend[3]), 1);
        run_to(50);
        chk("t2_e50_clk3", 32'(clk_out[3]), 0);
        chk("t2_e50_pend3", 32'(pend[3]), 0);
        run_to(59);
        chk("t2_e59_clk3", 32'(clk_out[3]), 0);
        run_to(60);
        chk("t2_e60_tick3", 32'(tick[3]), 1);
        run_to(70);
        chk("t2_e70_clk3", 32'(clk_out[3]), 0);
        run_to(80);
        chk("t2_e80_clk3", 32'(clk_out[3]), 1);

        // ch2: H=1, then H=0 on a boundary, then recovery with H=4
        reset_dut();
        wr(4'd2, 26'd1);
        run_to(1);
        cfg.cfg_we = 1'b0;
        chk("t3_e1_pend2", 32'(pend[2]), 1);
        run_to(5);
        chk("t3_e5_clk2", 32'(clk_out[2]), 0);
        run_to(6);
        chk("t3_e6_clk2", 32'(clk_out[2]), 1);
        chk("t3_e6_tick2", 32'(tick[2]), 1);
        run_to(7);
        chk("t3_e7_tick2", 32'(tick[2]), 0);
        run_to(8);
        chk("t3_e8_tick2", 32'(tick[2]), 1);
        wr(4'd2, 26'd0);
        run_to(9);
        cfg.cfg_we = 1'b0;
        chk("t3_e9_clk2", 32'(clk_out[2]), 0);
        chk("t3_e9_pend2", 32'(pend[2]), 1);
        run_to(10);
        chk("t3_e10_clk2", 32'(clk_out[2]), 1);
        chk("t3_e10_pend2", 32'(pend[2]), 0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) bad++;
        end
        chk("t3_h0_hold", 32'(bad), 0);
        wr(4'd2, 26'd4);
        run_to(21);
        cfg.cfg_we = 1'b0;
        run_to(25);
        chk("t3_e25_clk2", 32'(clk_out[2]), 0);
        run_to(26);
        chk("t3_e26_tick2", 32'(tick[2]), 1);
        run_to(30);
        chk("t3_e30_clk2", 32'(clk_out[2]), 0);
        run_to(33);
        chk("t3_e33_clk2", 32'(clk_out[2]), 0);
        run_to(34);
        chk("t3_e34_tick2", 32'(tick[2]), 1);

        // ch1 enable dropped for 100 cycles in its high phase
        reset_dut();
        run_to(8);
        chk("t4_e8_clk1", 32'(clk_out[1]), 1);
        en[1] = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (clk_out[1] !== 1'b1 || tick[1] !== 1'b0) bad++;
        end
        chk("t4_freeze", 32'(bad), 0);
        en[1] = 1'b1;
        run_to(111);
        chk("t4_e111_clk1", 32'(clk_out[1]), 1);
        run_to(112);
        chk("t4_e112_clk1", 32'(clk_out[1]), 0);
        run_to(117);
        chk("t4_e117_clk1", 32'(clk_out[1]), 0);
        run_to(118);
        chk("t4_e118_tick1", 32'(tick[1]), 1);

        // Out-of-range write, then a write on ch3's boundary cycle
        reset_dut();
        wr(4'd7, 26'd2);
        run_to(1);
        cfg.cfg_we = 1'b0;
        chk("t5_oor_pend", 32'(pend), 0);
        run_to(3);
        chk("t5_e3_clk0", 32'(clk_out[0]), 1);
        run_to(24);
        wr(4'd3, 26'd10);
        run_to(25);
        cfg.cfg_we = 1'b0;
        chk("t5_e25_clk3", 32'(clk_out[3]), 1);
        chk("t5_e25_pend3", 32'(pend[3]), 1);
        run_to(35);
        chk("t5_e35_clk3", 32'(clk_out[3]), 1);
        run_to(50);
        chk("t5_e50_clk3", 32'(clk_out[3]), 0);
        chk("t5_e50_pend3", 32'(pend[3]), 0);
        run_to(60);
        chk("t5_e60_tick3", 32'(tick[3]), 1);

        // resync with a concurrent write, then rst against resync
        reset_dut();
        run_to(30);
        resync = 1'b1;
        wr(4'd2, 26'd5);
        run_to(31);
        resync     = 1'b0;
        cfg.cfg_we = 1'b0;
        chk("t6_rs_clk", 32'(clk_out), 0);
        chk("t6_rs_tick", 32'(tick), 0);
        chk("t6_rs_pend", 32'(pend), 32'h4);
        run_to(34);
        chk("t6_e34_clk", 32'(clk_out), 32'h1);
        run_to(35);
        chk("t6_e35_clk", 32'(clk_out), 32'h5);
        chk("t6_e35_pend", 32'(pend), 0);
        run_to(37);
        chk("t6_e37_clk", 32'(clk_out), 32'h6);
        run_to(39);
        chk("t6_e39_clk2", 32'(clk_out[2]), 1);
        run_to(40);
        chk("t6_e40_clk2", 32'(clk_out[2]), 0);
        run_to(56);
        chk("t6_e56_tick3", 32'(tick[3]), 1);
        run_to(60);
        rst    = 1'b1;
        resync = 1'b1;
        wr(4'd0, 26'd9);
        cyc();
        rst        = 1'b0;
        resync     = 1'b0;
        cfg.cfg_we = 1'b0;
        e          = 0;
        chk("t6_rst_clk", 32'(clk_out), 0);
        chk("t6_rst_pend", 32'(pend), 0);
        run_to(3);
        chk("t6_rst_e3_clk0", 32'(clk_out[0]), 1);
        run_to(4);
        chk("t6_rst_e4_clk2", 32'(clk_out[2]), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
